// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 fetch-side types and constants
//
// Purpose: address width, the {pc, instr} entry carried from fetch to decode,
// and the depth of the fetch-side buffer.
// Ports: none (package).
package riscv_pkg;

  localparam int ALEN            = 32;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int FETCH_ENTRY_W   = ALEN + 32;

  typedef struct packed {
    logic [ALEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry FIFO of {pc, instr} between fetch and decode
//
// Purpose: absorbs the fetch pipeline while decode back-pressures.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        drop all entries; beats push_i and pop_i
//   push_i         write push_data_i at the tail
//   push_data_i    fetch_entry_t as a flat vector
//   pop_i          remove the head (ignored when empty)
//   occ_o          number of valid entries (0..2)
//   head_o         oldest entry, meaningful when occ_o != 0
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [FETCH_ENTRY_W-1:0] push_data_i,
  input  logic                     pop_i,
  output logic [1:0]               occ_o,
  output logic [FETCH_ENTRY_W-1:0] head_o
);

  // Entry 0 is always the head; a pop shifts entry 1 down.
  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;
  fetch_entry_t in_entry;

  assign in_entry = fetch_entry_t'(push_data_i);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) e0_d = in_entry;
          else               e1_d = in_entry;
          if (occ_q != 2'd2) occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q != 2'd0) begin
            e0_d  = e1_q;
            occ_d = occ_q - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push and pop keeps the occupancy; an empty buffer
          // has nothing to pop so it just takes the new entry.
          if (occ_q == 2'd0) begin
            e0_d  = in_entry;
            occ_d = 2'd1;
          end else if (occ_q == 2'd1) begin
            e0_d = in_entry;
          end else begin
            e0_d = e1_q;
            e1_d = in_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = e0_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC owner and ROM initiator feeding decode
//
// Purpose: issues sequential reads to a 1-cycle-latency instruction ROM,
// captures responses with their PC and hands {pc, instr} to decode over a
// valid/ready handshake, squashing in-flight work on redirect.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_en, imem_addr            ROM read request
//   imem_rdata                    ROM data, valid the cycle after imem_en
//   redirect_valid, redirect_pc   new fetch PC from branch/jump resolution
//   out_valid, out_ready          handshake to decode
//   out_pc, out_instr             entry presented to decode
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [ALEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [ALEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [ALEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ALEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  logic [ALEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [ALEN-1:0] inflight_pc_q, inflight_pc_d;

  logic [1:0]               occ;
  logic [FETCH_ENTRY_W-1:0] head_flat;
  fetch_entry_t             head;
  fetch_entry_t             push_entry;
  logic                     deq;
  logic                     issue;
  logic                     push;

  assign head = fetch_entry_t'(head_flat);
  assign deq  = out_valid & out_ready;

  // Buffered plus in-flight entries never exceed the buffer depth, so a
  // response always has a slot; a same-cycle dequeue frees one.
  assign issue = !rst && !redirect_valid &&
                 ((({1'b0, occ} + {2'b00, inflight_q}) < 3'(FETCH_BUF_DEPTH)) || deq);

  // A response is taken only for a read issued last cycle, so the ROM's
  // behaviour while not enabled never matters.
  assign push = inflight_q & !redirect_valid;

  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = imem_rdata;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ALEN-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ALEN'(4);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_buffer u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (deq),
    .occ_o       (occ),
    .head_o      (head_flat)
  );

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (occ != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && occ == 2'd2 && !deq));
    end
  end

endmodule
